axis_flit_packetizer: RTL
=========================

# axis_flit_packetizer

- Converts the AXI-Stream manager output of a tile's processing element (m_axis side) into network flits for the injection port of the tile's switch.
- Each AXIS packet (beats up to and including `tlast`) becomes one header flit followed by one flit per beat; the last beat is marked as a tail flit.
- Flit injection is gated by per-virtual-channel credits returned through the switch `go` signals.
- Sits between the PE/VIP m_axis interface and the switch local input port, in the AXIS manager clock domain.

## Interface
Parameters:
- `NetworkSwitchAddressId`, 0: this tile's switch id, written into headers.
- `NetworkSwitchAddressIdWidth`, 4: width of the switch id.
- `NetworkIfFlitWidth`, 64: flit payload width. Must equal `AxiStreamInitiatorIfTDataWidth`.
- `NetworkIfFlitTypeWidth`, 2: flit type width.
- `NetworkIfBroadcastWidth`, 1: broadcast field width. Always driven 0.
- `NetworkIfVirtualChannelIdWidth`, 1: VC id width.
- `NetworkIfNumberOfVirtualChannels`, 2: number of VCs.
- `CreditsPerVirtualChannel`, 8: downstream buffer depth per VC.
- `AxiStreamInitiatorIfTDataWidth`, 64; `AxiStreamInitiatorIfTIdWidth`, 4; `AxiStreamInitiatorIfTDestWidth`, 4: AXIS field widths.
- `MaxPayloadFlits`, 16: used only with the configuration macro.

Ports:
- `clk_m_axis_i` in 1: the block's only clock.
- `rst_m_axis_ni` in 1: asynchronous, active-low reset.
- `s_axis_tvalid` in 1; `s_axis_tready` out 1; `s_axis_tdata` in TData; `s_axis_tlast` in 1; `s_axis_tid` in TId; `s_axis_tdest` in TDest.
- `network_valid_o` out 1: flit valid, one cycle per flit.
- `network_data_o` out FlitWidth+FlitTypeWidth+BroadcastWidth+VirtualChannelIdWidth. Packed, MSB to LSB: {flit, type, broadcast, vc}.
- `network_go_i` in NumberOfVirtualChannels: one-cycle credit-return pulse per VC.

## Operation
- Flit types:
  - HEADER = 2'b00
  - BODY = 2'b01
  - TAIL = 2'b10
  - 2'b11 is never emitted.
- Header flit payload, LSB upward: `tdest`, `tid`, `NetworkSwitchAddressId`; upper bits 0.
- VC selection: `vc = tid[VirtualChannelIdWidth-1:0]`. The VC is latched at the header and held for the whole packet.
- FSM states:
  - IDLE: `tready` is 0. When `tvalid` is 1, latch `tid`/`tdest`/`vc` and go to HEAD.
  - HEAD: when `credit[vc]>0`, emit the header flit and go to BODY; otherwise wait in HEAD.
  - BODY: `tready = (credit[vc]>0)`. Each accepted beat emits one flit: BODY, or TAIL if `tlast`. On a `tlast` beat, go to IDLE.
- Credit counters:
  - Each VC counter resets to `CreditsPerVirtualChannel`.
  - Decrement by 1 on every emitted flit of that VC.
  - Increment by 1 on `network_go_i[vc]`.
  - Emit and go on the same VC in the same cycle: counter unchanged.
  - A go pulse when the counter is full is a protocol error (simulation assertion); the counter saturates.
- Zero credits: hold state and `tready=0`. No flit is dropped or duplicated.
- Single-beat packet: HEADER then TAIL.
- Reset mid-packet: outputs and state return to reset values immediately. The partial packet is abandoned; downstream shares the same reset.

## Timing
- Reset values: `s_axis_tready=0`, `network_valid_o=0`, `network_data_o=0`, state IDLE, all credits full.
- Outputs are registered.
- `tvalid` rising in IDLE at cycle 0 → header valid at cycle 2 (HEAD entered cycle 1, flit registered).
- A beat accepted at cycle n → its flit valid at cycle n+1.
- Steady-state throughput with credits available: 1 flit per cycle.
- Per packet, 2 cycles of overhead (IDLE, HEAD).
- A credit returned at cycle n is usable at cycle n+1.

## Configuration
- `AXIS_PACKETIZER_MAX_LEN_EN` defined: after `MaxPayloadFlits` payload flits without `tlast`, the last of them is emitted as TAIL. The FSM re-enters HEAD with the same latched `tid`/`tdest`/`vc` and continues the stream as a new packet.
- Not defined: packet length is unbounded and `MaxPayloadFlits` is ignored.

## Structure
- Package `noc_flit_pkg` holds:
  - flit type constants
  - FSM state enum
  - header field offset constants
- Sub-module `noc_vc_credit_counter`: one instance per VC, with ports `consume`, `release`, and `available`.

## Test plan
- Single packet, 3 beats (tdata 0xA,0xB,0xC, tlast on 0xC), tid=1, tdest=5, SwitchId=2:
  - Flits are HEADER (payload 0x215), BODY 0xA, BODY 0xB, TAIL 0xC.
  - All carry vc=1, on consecutive cycles.
- Single beat with tlast, tid=0 → HEADER then TAIL 0xD, vc=0.
- Credits 8, no go pulses, 12-beat packet:
  - Header plus 7 payload flits are emitted, then `tready` stays 0.
  - 5 go pulses → the remaining 5 flits are emitted and the packet completes.
- Go pulse on the same cycle as a flit emit on vc 0: credit stays at its value and the emit proceeds.
- Reset asserted after the 2nd beat of a 4-beat packet:
  - `valid_o`/`tready` are 0 immediately and credits return to 8.
  - The next packet starts with a HEADER.
- With `AXIS_PACKETIZER_MAX_LEN_EN` and `MaxPayloadFlits=4`, a 6-beat packet produces:
  - HEADER, BODY, BODY, BODY, TAIL
  - HEADER, BODY, TAIL

Source files
------------

// File: rtl/noc_flit_pkg.sv
// Shared definitions for the AXIS-to-flit packetizer: flit type codes,
// packetizer FSM states and header field placement.
package noc_flit_pkg;

    // Flit type codes; 2'b11 is reserved and never emitted.
    localparam logic [1:0] FlitHeader = 2'b00;
    localparam logic [1:0] FlitBody   = 2'b01;
    localparam logic [1:0] FlitTail   = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StHead,
        StBody
    } pkt_state_e;

    // Header payload layout, LSB upward: tdest, tid, switch id, zeros.
    localparam int unsigned HdrTdestOffset = 0;

    function automatic int unsigned hdr_tid_offset(input int unsigned tdest_w);
        return HdrTdestOffset + tdest_w;
    endfunction

    function automatic int unsigned hdr_switch_offset(input int unsigned tdest_w,
                                                      input int unsigned tid_w);
        return hdr_tid_offset(tdest_w) + tid_w;
    endfunction

endpackage

// File: rtl/noc_vc_credit_counter.sv
// Credit counter for one virtual channel. Starts full, drops on each
// emitted flit, rises on each credit return from the switch.
module noc_vc_credit_counter #(
    parameter int unsigned Credits = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic consume,
    input  logic credit_release,
    output logic available,
    output logic available_next
);

    localparam int unsigned CntW = $clog2(Credits + 1);
    localparam logic [CntW-1:0] Full = CntW'(Credits);

    logic [CntW-1:0] count;
    logic [CntW-1:0] count_next;

    // Simultaneous consume and release cancel; a release while full saturates.
    always_comb begin
        count_next = count;
        if (consume && !credit_release) begin
            count_next = count - 1'b1;
        end else if (credit_release && !consume && (count != Full)) begin
            count_next = count + 1'b1;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= Full;
        end else begin
            count <= count_next;
        end
    end

    assign available      = (count != '0);
    assign available_next = (count_next != '0);

    // Returning a credit that was never taken means the downstream is broken.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(credit_release && !consume && (count == Full)))
        else $error("credit return on a full counter");

endmodule

// File: rtl/axis_flit_packetizer.sv
// AXI-Stream to NoC flit packetizer. Each AXIS packet becomes a header flit
// followed by one flit per beat, the last one typed TAIL. Injection is gated
// by per-VC credits returned on network_go_i.
// Optional feature: define AXIS_PACKETIZER_MAX_LEN_EN to split packets after
// MaxPayloadFlits payload flits; the remainder continues as a new packet.
module axis_flit_packetizer
    import noc_flit_pkg::*;
#(
    parameter int unsigned NetworkSwitchAddressId           = 0,
    parameter int unsigned NetworkSwitchAddressIdWidth      = 4,
    parameter int unsigned NetworkIfFlitWidth               = 64,
    parameter int unsigned NetworkIfFlitTypeWidth           = 2,
    parameter int unsigned NetworkIfBroadcastWidth          = 1,
    parameter int unsigned NetworkIfVirtualChannelIdWidth   = 1,
    parameter int unsigned NetworkIfNumberOfVirtualChannels = 2,
    parameter int unsigned CreditsPerVirtualChannel         = 8,
    parameter int unsigned AxiStreamInitiatorIfTDataWidth   = 64,
    parameter int unsigned AxiStreamInitiatorIfTIdWidth     = 4,
    parameter int unsigned AxiStreamInitiatorIfTDestWidth   = 4,
    parameter int unsigned MaxPayloadFlits                  = 16
) (
    input  logic                                      clk_m_axis_i,
    input  logic                                      rst_m_axis_ni,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    input  logic [AxiStreamInitiatorIfTDataWidth-1:0] s_axis_tdata,
    input  logic                                      s_axis_tlast,
    input  logic [AxiStreamInitiatorIfTIdWidth-1:0]   s_axis_tid,
    input  logic [AxiStreamInitiatorIfTDestWidth-1:0] s_axis_tdest,
    output logic                                      network_valid_o,
    output logic [NetworkIfFlitWidth+NetworkIfFlitTypeWidth+NetworkIfBroadcastWidth+
                  NetworkIfVirtualChannelIdWidth-1:0] network_data_o,
    input  logic [NetworkIfNumberOfVirtualChannels-1:0] network_go_i
);

    localparam int unsigned FlitW     = NetworkIfFlitWidth;
    localparam int unsigned TypeW     = NetworkIfFlitTypeWidth;
    localparam int unsigned BcW       = NetworkIfBroadcastWidth;
    localparam int unsigned VcW       = NetworkIfVirtualChannelIdWidth;
    localparam int unsigned NumVc     = NetworkIfNumberOfVirtualChannels;
    localparam int unsigned TIdW      = AxiStreamInitiatorIfTIdWidth;
    localparam int unsigned TDestW    = AxiStreamInitiatorIfTDestWidth;
    localparam int unsigned SwW       = NetworkSwitchAddressIdWidth;
    localparam int unsigned TidOffset = hdr_tid_offset(TDestW);
    localparam int unsigned SwOffset  = hdr_switch_offset(TDestW, TIdW);

    if (NetworkIfFlitWidth != AxiStreamInitiatorIfTDataWidth) begin : g_bad_width
        $error("flit width must equal AXIS tdata width");
    end
    if (MaxPayloadFlits < 1) begin : g_bad_max_len
        $error("MaxPayloadFlits must be at least 1");
    end

    pkt_state_e         state;
    logic [TIdW-1:0]    tid_q;
    logic [TDestW-1:0]  tdest_q;
    logic [VcW-1:0]     vc_q;
    logic [FlitW-1:0]   hdr_payload;
    logic [NumVc-1:0]   consume;
    logic [NumVc-1:0]   avail;
    logic [NumVc-1:0]   avail_next;
    logic               beat_accept;
    logic               emit;

`ifdef AXIS_PACKETIZER_MAX_LEN_EN
    localparam int unsigned PayW = $clog2(MaxPayloadFlits + 1);
    logic [PayW-1:0] pay_cnt;
`endif

    // tready is only ever high with a credit in hand, so an accepted beat always emits.
    assign beat_accept = s_axis_tvalid && s_axis_tready;
    assign emit        = ((state == StHead) && avail[vc_q]) || beat_accept;

    // Header payload assembled from the latched packet fields.
    always_comb begin
        hdr_payload                            = '0;
        hdr_payload[HdrTdestOffset +: TDestW]  = tdest_q;
        hdr_payload[TidOffset +: TIdW]         = tid_q;
        hdr_payload[SwOffset +: SwW]           = SwW'(NetworkSwitchAddressId);
    end

    // Charge the credit of the packet's VC for every emitted flit.
    always_comb begin
        consume = '0;
        if (emit) begin
            consume = NumVc'(1) << vc_q;
        end
    end

    for (genvar v = 0; v < NumVc; v++) begin : g_vc
        noc_vc_credit_counter #(
            .Credits(CreditsPerVirtualChannel)
        ) u_credit (
            .clk           (clk_m_axis_i),
            .rst_n         (rst_m_axis_ni),
            .consume       (consume[v]),
            .credit_release(network_go_i[v]),
            .available     (avail[v]),
            .available_next(avail_next[v])
        );
    end

    // Packet FSM with registered flit and tready outputs; tready looks one
    // cycle ahead using the counter's next value.
    always_ff @(posedge clk_m_axis_i or negedge rst_m_axis_ni) begin
        if (!rst_m_axis_ni) begin
            state           <= StIdle;
            tid_q           <= '0;
            tdest_q         <= '0;
            vc_q            <= '0;
            s_axis_tready   <= 1'b0;
            network_valid_o <= 1'b0;
            network_data_o  <= '0;
`ifdef AXIS_PACKETIZER_MAX_LEN_EN
            pay_cnt         <= '0;
`endif
        end else begin
            network_valid_o <= 1'b0;
            unique case (state)
                StIdle: begin
                    s_axis_tready <= 1'b0;
                    if (s_axis_tvalid) begin
                        tid_q   <= s_axis_tid;
                        tdest_q <= s_axis_tdest;
                        vc_q    <= s_axis_tid[VcW-1:0];
                        state   <= StHead;
                    end
                end
                StHead: begin
                    s_axis_tready <= 1'b0;
                    if (avail[vc_q]) begin
                        network_valid_o <= 1'b1;
                        network_data_o  <= {hdr_payload, TypeW'(FlitHeader), {BcW{1'b0}}, vc_q};
                        s_axis_tready   <= avail_next[vc_q];
                        state           <= StBody;
`ifdef AXIS_PACKETIZER_MAX_LEN_EN
                        pay_cnt         <= '0;
`endif
                    end
                end
                StBody: begin
                    s_axis_tready <= avail_next[vc_q];
                    if (beat_accept) begin
                        network_valid_o <= 1'b1;
                        if (s_axis_tlast) begin
                            network_data_o <= {s_axis_tdata, TypeW'(FlitTail), {BcW{1'b0}}, vc_q};
                            s_axis_tready  <= 1'b0;
                            state          <= StIdle;
`ifdef AXIS_PACKETIZER_MAX_LEN_EN
                        end else if (pay_cnt == PayW'(MaxPayloadFlits - 1)) begin
                            // Length cap reached: close this packet, reopen with same fields.
                            network_data_o <= {s_axis_tdata, TypeW'(FlitTail), {BcW{1'b0}}, vc_q};
                            s_axis_tready  <= 1'b0;
                            state          <= StHead;
                        end else begin
                            network_data_o <= {s_axis_tdata, TypeW'(FlitBody), {BcW{1'b0}}, vc_q};
                            pay_cnt        <= pay_cnt + 1'b1;
`else
                        end else begin
                            network_data_o <= {s_axis_tdata, TypeW'(FlitBody), {BcW{1'b0}}, vc_q};
`endif
                        end
                    end
                end
                default: begin
                    s_axis_tready <= 1'b0;
                    state         <= StIdle;
                end
            endcase
        end
    end

endmodule
